alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits (legal range 4..32).
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of the iteration counter.
REQ-003 Port clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port in_valid  input  1  operation request valid.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port op  input  4  opcode: 0010 ADD, 0011 SUB, 0100 SHL, 0101 SHR, 0110 AND, 0111 OR, 1000 XOR, 1001 POPCNT, 1010 CMP; all others NOP.
REQ-008 Port acc_in  input  WIDTH  accumulator operand.
REQ-009 Port reg_in  input  WIDTH  register operand; also the shift amount for SHL and SHR, and the popcount source.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port out  output  WIDTH  registered result.
REQ-013 Ports z, c, n, v  output  1 each  registered zero, carry/borrow, negative and overflow flags.

Function
REQ-014 FSM states SHALL be IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE and while reset is low.
REQ-015 A request SHALL be accepted on a clk edge where the state is IDLE and in_valid=1; op, acc_in and reg_in SHALL be captured at that edge, and later input changes SHALL have no effect.
REQ-016 ADD, SUB, AND, OR, XOR, CMP and NOP SHALL go IDLE->DONE, with out_valid=1 exactly one cycle after acceptance.
REQ-017 SHL and SHR SHALL shift the operand by one bit per BUSY cycle, k=min(reg_in,WIDTH) cycles in total, with zero fill; out_valid SHALL rise k+1 cycles after acceptance, so k=0 goes straight to DONE and any reg_in>=WIDTH yields 0.
REQ-018 POPCNT SHALL scan one bit of reg_in per BUSY cycle for WIDTH cycles; out_valid SHALL rise WIDTH+1 cycles after acceptance; out SHALL equal the number of set bits (0..WIDTH).
REQ-019 ADD SHALL compute {c,out}=acc_in+reg_in at WIDTH+1 bits; SUB SHALL compute {c,out}=acc_in-reg_in at WIDTH+1 bits, so c=1 signals a borrow.
REQ-020 ADD and SUB SHALL set v to two's-complement signed overflow and set z=(out==0), n=out[WIDTH-1].
REQ-021 AND, OR, XOR, SHL, SHR and POPCNT SHALL set z and n from out and leave c and v unchanged.
REQ-022 CMP SHALL set out=0, z=(acc_in==reg_in) and n=(acc_in<reg_in, unsigned), and leave c and v unchanged.
REQ-023 NOP SHALL set out=0 and leave all flags unchanged.
REQ-024 out and flags SHALL update only on the edge that enters DONE, and SHALL hold until the next operation completes.
REQ-025 DONE SHALL hold out_valid=1 until out_ready=1, then return to IDLE on the next edge; a new request SHALL NOT be accepted in the same cycle as the handshake.
REQ-026 Changes on out_ready while in IDLE or BUSY SHALL be ignored.
REQ-027 The block SHALL contain no latches and no simulation display statements.

Reset
REQ-028 While reset=1 at a clk edge, the state SHALL go to IDLE, out, z, c, n, v, out_valid and the counter SHALL go to 0, and in_ready SHALL be 0.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation, the pending result SHALL be lost, and no out_valid pulse SHALL follow.
REQ-030 The first request SHALL be accepted on the first edge after reset falls at which in_valid=1.

Configuration
REQ-031 Macro ALU_SEQ_POPCNT_EN defined: POPCNT SHALL behave as REQ-018.
REQ-032 Macro ALU_SEQ_POPCNT_EN undefined: opcode 1001 SHALL be treated as NOP (latency 1, out=0, flags unchanged), and no popcount logic SHALL be synthesised.

Verification
REQ-033 WIDTH=8, ADD acc=200 reg=100 -> out=44, c=1, v=0, z=0, n=0, and out_valid one cycle after acceptance.
REQ-034 WIDTH=8, SUB acc=5 reg=7 -> out=254, c=1, n=1; then ADD 100+100 -> out=200, v=1, n=1.
REQ-035 WIDTH=8, SHL acc=0x81 reg=3 -> out=0x08 with out_valid 4 cycles after acceptance; SHR reg=9 -> out=0 after 9 cycles.
REQ-036 WIDTH=8, POPCNT reg=0xB7 with the macro defined -> out=6 after 9 cycles; with the macro undefined -> out=0 after 1 cycle with flags unchanged.
REQ-037 CMP acc=9 reg=9 -> z=1, n=0; then CMP 3 vs 9 -> z=0, n=1; c and v hold their prior values in both cases.
REQ-038 out_ready held at 0 for 5 cycles in DONE -> out and out_valid stable and in_ready=0; reset pulsed mid-SHL -> IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, and multi-cycle shifts (plus popcount) behind a valid/ready handshake.
// Define ALU_SEQ_POPCNT_EN to build the bit-serial popcount; otherwise opcode 1001 is a NOP.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] reg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             c,
    output logic             n,
    output logic             v
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
`ifdef ALU_SEQ_POPCNT_EN
    localparam logic [3:0] OP_POPCNT = 4'b1001;
`endif

    state_t           state_reg, state_next;
    logic [3:0]       op_reg, op_next;
    logic [WIDTH-1:0] opnd_reg, opnd_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             z_reg, z_next, c_reg, c_next, n_reg, n_next, v_reg, v_next;
    logic             zn_upd;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] shifted;
`ifdef ALU_SEQ_POPCNT_EN
    logic [CNT_W-1:0] pop_reg, pop_next, pop_sum;
    assign pop_sum = pop_reg + CNT_W'(opnd_reg[0]);
`endif

    assign sum     = {1'b0, acc_in} + {1'b0, reg_in};
    assign diff    = {1'b0, acc_in} - {1'b0, reg_in};
    assign shifted = (op_reg == OP_SHL) ? (opnd_reg << 1) : (opnd_reg >> 1);

    assign in_ready  = (state_reg == IDLE) && !reset;
    assign out_valid = (state_reg == DONE);
    assign out       = out_reg;
    assign z         = z_reg;
    assign c         = c_reg;
    assign n         = n_reg;
    assign v         = v_reg;

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        opnd_next  = opnd_reg;
        out_next   = out_reg;
        cnt_next   = cnt_reg;
        z_next     = z_reg;
        c_next     = c_reg;
        n_next     = n_reg;
        v_next     = v_reg;
        zn_upd     = 1'b0;
`ifdef ALU_SEQ_POPCNT_EN
        pop_next   = pop_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    op_next    = op;
                    state_next = DONE;
                    case (op)
                        OP_ADD: begin
                            out_next = sum[WIDTH-1:0];
                            c_next   = sum[WIDTH];
                            v_next   = (acc_in[WIDTH-1] == reg_in[WIDTH-1]) &&
                                       (sum[WIDTH-1] != acc_in[WIDTH-1]);
                            zn_upd   = 1'b1;
                        end
                        OP_SUB: begin
                            out_next = diff[WIDTH-1:0];
                            c_next   = diff[WIDTH];
                            v_next   = (acc_in[WIDTH-1] != reg_in[WIDTH-1]) &&
                                       (diff[WIDTH-1] != acc_in[WIDTH-1]);
                            zn_upd   = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            // A zero shift amount completes immediately with the operand unchanged
                            if (reg_in == '0) begin
                                out_next = acc_in;
                                zn_upd   = 1'b1;
                            end else begin
                                opnd_next  = acc_in;
                                cnt_next   = (reg_in >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH)
                                                                       : reg_in[CNT_W-1:0];
                                state_next = BUSY;
                            end
                        end
                        OP_AND: begin out_next = acc_in & reg_in; zn_upd = 1'b1; end
                        OP_OR:  begin out_next = acc_in | reg_in; zn_upd = 1'b1; end
                        OP_XOR: begin out_next = acc_in ^ reg_in; zn_upd = 1'b1; end
`ifdef ALU_SEQ_POPCNT_EN
                        OP_POPCNT: begin
                            opnd_next  = reg_in;
                            cnt_next   = CNT_W'(WIDTH);
                            pop_next   = '0;
                            state_next = BUSY;
                        end
`endif
                        OP_CMP: begin
                            out_next = '0;
                            z_next   = (acc_in == reg_in);
                            n_next   = (acc_in < reg_in);
                        end
                        default: out_next = '0;
                    endcase
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 1'b1;
`ifdef ALU_SEQ_POPCNT_EN
                if (op_reg == OP_POPCNT) begin
                    pop_next  = pop_sum;
                    opnd_next = opnd_reg >> 1;
                    if (cnt_reg == CNT_W'(1)) begin
                        out_next   = WIDTH'(pop_sum);
                        zn_upd     = 1'b1;
                        state_next = DONE;
                    end
                end else
`endif
                begin
                    opnd_next = shifted;
                    if (cnt_reg == CNT_W'(1)) begin
                        out_next   = shifted;
                        zn_upd     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (zn_upd) begin
            z_next = (out_next == '0);
            n_next = out_next[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            opnd_reg  <= '0;
            out_reg   <= '0;
            cnt_reg   <= '0;
            z_reg     <= 1'b0;
            c_reg     <= 1'b0;
            n_reg     <= 1'b0;
            v_reg     <= 1'b0;
`ifdef ALU_SEQ_POPCNT_EN
            pop_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            opnd_reg  <= opnd_next;
            out_reg   <= out_next;
            cnt_reg   <= cnt_next;
            z_reg     <= z_next;
            c_reg     <= c_next;
            n_reg     <= n_next;
            v_reg     <= v_next;
`ifdef ALU_SEQ_POPCNT_EN
            pop_reg   <= pop_next;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a reference model pushes expected results to a queue,
// popped and compared when out_valid rises.
module tb_alu_seq;
    logic       clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] op;
    logic [7:0] acc_in, reg_in, out;
    logic       z, c, n, v;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] out;
        logic z, c, n, v;
        int lat;
    } exp_t;
    exp_t exp_q[$];
    logic m_z = 0, m_c = 0, m_n = 0, m_v = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_in(acc_in), .reg_in(reg_in), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .z(z), .c(c), .n(n), .v(v)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int sx(input logic [7:0] x);
        return (x >= 128) ? int'(x) - 256 : int'(x);
    endfunction

    // Reference model: integer arithmetic, flag state carried between operations
    task automatic model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int s, k;
        logic upd;
        e.out = 0; e.lat = 1; upd = 0;
        k = (int'(b) > 8) ? 8 : int'(b);
        case (o)
            4'h2: begin s = int'(a) + int'(b); e.out = 8'(s); m_c = (s > 255);
                        s = sx(a) + sx(b); m_v = (s > 127) || (s < -128); upd = 1; end
            4'h3: begin s = int'(a) - int'(b); e.out = 8'(s); m_c = (s < 0);
                        s = sx(a) - sx(b); m_v = (s > 127) || (s < -128); upd = 1; end
            4'h4: begin e.out = (k >= 8) ? 8'd0 : 8'(int'(a) << k); e.lat = k + 1; upd = 1; end
            4'h5: begin e.out = (k >= 8) ? 8'd0 : 8'(int'(a) >> k); e.lat = k + 1; upd = 1; end
            4'h6: begin e.out = a & b; upd = 1; end
            4'h7: begin e.out = a | b; upd = 1; end
            4'h8: begin e.out = a ^ b; upd = 1; end
`ifdef ALU_SEQ_POPCNT_EN
            4'h9: begin e.out = 8'($countones(b)); e.lat = 9; upd = 1; end
`endif
            4'hA: begin m_z = (a == b); m_n = (a < b); end
            default: ;
        endcase
        if (upd) begin m_z = (e.out == 0); m_n = e.out[7]; end
        e.z = m_z; e.c = m_c; e.n = m_n; e.v = m_v;
        exp_q.push_back(e);
    endtask

    task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input int stall);
        exp_t e;
        int lat;
        logic [7:0] held;
        model(o, a, b);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1; op = o; acc_in = a; reg_in = b;
        @(posedge clk); #1;
        in_valid = 0; op = 4'($urandom); acc_in = 8'($urandom); reg_in = 8'($urandom);
        out_ready = (stall == 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        e = exp_q.pop_front();
        check("latency", lat, e.lat);
        check("out", out, e.out);
        check("z", z, e.z);
        check("c", c, e.c);
        check("n", n, e.n);
        check("v", v, e.v);
        $display("op=%h a=%02h b=%02h out=%02h zcnv=%b%b%b%b lat=%0d", o, a, b, out, z, c, n, v, lat);
        held = out;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_out", out, held);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        if (stall > 0) begin
            in_valid = 1; op = 4'hA;
        end
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_out_hold", out, e.out);
    endtask

    initial begin
        int seen;
        reset = 1; in_valid = 0; out_ready = 0; op = 0; acc_in = 0; reg_in = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_flags", {z, c, n, v}, 0);
        reset = 0;
        #1 check("in_ready_after_rst", in_ready, 1);

        do_op(4'h2, 8'd200, 8'd100, 0);
        check("add_out", out, 44); check("add_c", c, 1); check("add_v", v, 0);
        do_op(4'h3, 8'd5, 8'd7, 0);
        check("sub_out", out, 254); check("sub_c", c, 1); check("sub_n", n, 1);
        do_op(4'h2, 8'd100, 8'd100, 0);
        check("add_ovf_out", out, 200); check("add_ovf_v", v, 1); check("add_ovf_n", n, 1);
        do_op(4'h4, 8'h81, 8'd3, 0);
        check("shl_out", out, 8'h08);
        do_op(4'h5, 8'h81, 8'd9, 0);
        check("shr9_out", out, 0);
        do_op(4'h5, 8'hC4, 8'd2, 0);
        do_op(4'h4, 8'h5A, 8'd0, 0);
        do_op(4'h4, 8'hFF, 8'd8, 0);
        do_op(4'h2, 8'd200, 8'd100, 0);   // leaves c=1 so the POPCNT and CMP hold checks mean something
        do_op(4'h9, 8'h00, 8'hB7, 0);
`ifdef ALU_SEQ_POPCNT_EN
        check("popcnt_out", out, 6);
`else
        check("popcnt_nop_out", out, 0);
        check("popcnt_nop_c", c, 1);
`endif
        do_op(4'hA, 8'd9, 8'd9, 0);
        check("cmp_eq_z", z, 1); check("cmp_eq_n", n, 0); check("cmp_eq_c", c, 1);
        do_op(4'hA, 8'd3, 8'd9, 0);
        check("cmp_lt_z", z, 0); check("cmp_lt_n", n, 1); check("cmp_lt_c", c, 1);
        for (int i = 0; i < 3; i++)
            do_op(4'(6 + i), 8'($urandom), 8'($urandom), 0);
        do_op(4'h0, 8'h12, 8'h34, 0);
        do_op(4'hF, 8'h00, 8'h00, 0);
        do_op(4'h3, 8'h80, 8'h01, 0);
        check("sub_ovf_v", v, 1);
        do_op(4'h2, 8'd200, 8'd100, 5);

        // Reset during a shift must abort it with no result
        @(negedge clk);
        in_valid = 1; op = 4'h4; acc_in = 8'hFF; reg_in = 8'd7;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(negedge clk);
        check("busy_no_valid", out_valid, 0);
        reset = 1;
        @(posedge clk); #1;
        check("abort_valid", out_valid, 0);
        check("abort_out", out, 0);
        check("abort_flags", {z, c, n, v}, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 0;
        #1 check("abort_idle", in_ready, 1);
        m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_pulse", seen, 0);
        do_op(4'h2, 8'd1, 8'd2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
